// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master
//   Load/store initiator for the word-wide, little-endian data port of the
//   unified RAM. Turns RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests into word
//   reads and writes. SB/SH become a read-modify-write because the RAM only
//   writes whole words. Alignment, range and the protected instruction
//   region are checked before any memory access. Each accepted request gets
//   exactly one response pulse.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE, never in reset)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32 width/sign code
//   req_addr          byte address
//   req_wdata         store data (low byte/halfword used for SB/SH)
//   resp_valid        one-cycle response pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_cause        0 ok, 1 misaligned, 2 access fault, 3 illegal funct3
//   dmem_wen/addr/wdata  RAM write enable, word-aligned address, write data
//   dmem_rdata        RAM read data, combinational from dmem_addr
module lsu_dmem_master #(
  parameter int          MEM_BYTES    = 16384,
  parameter logic [31:0] PROTECT_BASE = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_cause,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  localparam logic [1:0] CAUSE_OK    = 2'd0;
  localparam logic [1:0] CAUSE_MISAL = 2'd1;
  localparam logic [1:0] CAUSE_FAULT = 2'd2;
  localparam logic [1:0] CAUSE_ILL   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  state_t      state_reg;
  logic [1:0]  lane_reg;
  logic [2:0]  funct3_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic [1:0]  resp_cause_reg;
  logic        dmem_wen_reg;
  logic [31:0] dmem_addr_reg;
  logic [31:0] dmem_wdata_reg;

  // ---------------------------------------------------------------------
  // Request checks, evaluated on the incoming request at the accept edge
  // ---------------------------------------------------------------------
  logic [31:0] req_waddr;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_fault;
  logic [1:0]  req_cause;
  logic        req_is_sw;

  assign req_waddr = {req_addr[31:2], 2'b00};
  assign req_is_sw = (req_funct3 == 3'b010);

  always_comb begin
    req_illegal = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = req_we;  // BU/HU are load-only
      default:                req_illegal = 1'b1;
    endcase
  end

  assign req_misaligned = ((req_funct3 == 3'b001) && req_addr[0]) ||
                          ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

  assign req_fault = (req_waddr > LAST_WORD) ||
                     (req_we && (req_addr < PROTECT_BASE));

  always_comb begin
    req_cause = CAUSE_OK;
    if (req_illegal)
      req_cause = CAUSE_ILL;
    else if (req_misaligned)
      req_cause = CAUSE_MISAL;
    else if (req_fault)
      req_cause = CAUSE_FAULT;
  end

  // ---------------------------------------------------------------------
  // Load extraction from the word currently on dmem_rdata
  // ---------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (lane_reg)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
  end

  assign ld_half = lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_data = dmem_rdata;
    case (funct3_reg)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // Merge word for SB/SH: each byte lane either keeps the RAM byte or takes
  // the matching byte of the store data. dmem_wdata_reg still holds the
  // original store data while in RMW_RD, so it is the merge source.
  // ---------------------------------------------------------------------
  logic [31:0] merge_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
      logic lane_hit;
      logic [7:0] new_byte;
      // funct3_reg[0]: 0 = SB (single lane), 1 = SH (lane pair)
      assign lane_hit = funct3_reg[0] ? (lane_reg[1] == gi[1])
                                      : (lane_reg == gi[1:0]);
      assign new_byte = (funct3_reg[0] && gi[0]) ? dmem_wdata_reg[15:8]
                                                 : dmem_wdata_reg[7:0];
      assign merge_word[gi*8 +: 8] = lane_hit ? new_byte
                                              : dmem_rdata[gi*8 +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lane_reg       <= 2'd0;
      funct3_reg     <= 3'd0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_cause_reg <= CAUSE_OK;
      dmem_wen_reg   <= 1'b0;
      dmem_addr_reg  <= 32'd0;
      dmem_wdata_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            lane_reg   <= req_addr[1:0];
            funct3_reg <= req_funct3;
            if (req_cause != CAUSE_OK) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_cause_reg <= req_cause;
              resp_rdata_reg <= 32'd0;
            end else if (!req_we) begin
              state_reg     <= LOAD;
              dmem_addr_reg <= req_waddr;
            end else if (req_is_sw) begin
              state_reg      <= WRITE;
              dmem_addr_reg  <= req_waddr;
              dmem_wdata_reg <= req_wdata;
              dmem_wen_reg   <= 1'b1;
            end else begin
              // SB/SH: hold the store data in dmem_wdata_reg for the merge
              state_reg      <= RMW_RD;
              dmem_addr_reg  <= req_waddr;
              dmem_wdata_reg <= req_wdata;
            end
          end
        end

        LOAD: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
          resp_cause_reg <= CAUSE_OK;
          resp_rdata_reg <= ld_data;
          dmem_addr_reg  <= 32'd0;
        end

        RMW_RD: begin
          // address is unchanged: the write goes back to the word just read
          state_reg      <= WRITE;
          dmem_wdata_reg <= merge_word;
          dmem_wen_reg   <= 1'b1;
        end

        WRITE: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
          resp_cause_reg <= CAUSE_OK;
          resp_rdata_reg <= 32'd0;
          dmem_wen_reg   <= 1'b0;
          dmem_addr_reg  <= 32'd0;
          dmem_wdata_reg <= 32'd0;
        end

        RESP: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
        end

        default: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
          dmem_wen_reg   <= 1'b0;
          dmem_addr_reg  <= 32'd0;
          dmem_wdata_reg <= 32'd0;
        end
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE) && !rst;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_cause = resp_cause_reg;
  // Gating with rst keeps a reset that lands during WRITE from committing
  // a write in the same cycle.
  assign dmem_wen   = dmem_wen_reg && !rst;
  assign dmem_addr  = dmem_addr_reg;
  assign dmem_wdata = dmem_wdata_reg;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Testbench for lsu_dmem_master: table of directed requests applied against
// a word-wide RAM model, plus hand-written reset sequences.
module tb_lsu_dmem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  lsu_dmem_master #(
    .MEM_BYTES   (16384),
    .PROTECT_BASE(32'h0000_0400)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_cause(resp_cause),
    .dmem_wen  (dmem_wen),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 4096 words, one writer process (preload port has priority)
  logic [31:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_idx;
  logic [31:0] pre_data;
  logic        mem_clr;
  int          wr_count;
  int          bad_wr;
  logic [31:0] last_wr_addr;

  assign dmem_rdata = mem[dmem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (dmem_wen) begin
      mem[dmem_addr[13:2]] <= dmem_wdata;
    end
  end

  always @(posedge clk) begin
    if (dmem_wen) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= dmem_addr;
      if (dmem_addr[1:0] != 2'b00 || dmem_addr < 32'h400)
        bad_wr <= bad_wr + 1;
    end
  end

  int pass_count;
  int total_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;       // preload the target word with pre_word
    logic [31:0] pre_word;
    logic [1:0]  cause;
    logic [31:0] rdata;
    int          lat;       // edges from accept to resp_valid
    int          writes;    // expected number of dmem_wen cycles
    logic [31:0] mem_exp;   // target word afterwards (checked when pre)
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic pre, input logic [31:0] pre_word,
                              input logic [1:0] cause, input logic [31:0] rdata, input int lat,
                              input int writes, input logic [31:0] mem_exp);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.pre = pre;
    v.pre_word = pre_word; v.cause = cause; v.rdata = rdata; v.lat = lat;
    v.writes = writes; v.mem_exp = mem_exp;
    return v;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = addr[13:2]; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int          lat;
    int          wr0;
    logic [31:0] first_addr;
    logic [31:0] exp_first;
    if (v.pre) preload(v.addr, v.pre_word);
    @(negedge clk);
    check($sformatf("v%0d ready_before", n), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    wr0 = wr_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    first_addr = dmem_addr;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    exp_first = (v.cause == 2'd0) ? {v.addr[31:2], 2'b00} : 32'd0;
    check($sformatf("v%0d resp_valid", n), {31'd0, resp_valid}, 32'd1);
    check($sformatf("v%0d latency", n), lat, v.lat);
    check($sformatf("v%0d cause", n), {30'd0, resp_cause}, {30'd0, v.cause});
    check($sformatf("v%0d rdata", n), resp_rdata, v.rdata);
    check($sformatf("v%0d first_dmem_addr", n), first_addr, exp_first);
    check($sformatf("v%0d write_count", n), wr_count - wr0, v.writes);
    if (v.writes > 0)
      check($sformatf("v%0d write_addr", n), last_wr_addr, {v.addr[31:2], 2'b00});
    if (v.pre)
      check($sformatf("v%0d mem_word", n), mem[v.addr[13:2]], v.mem_exp);
    @(negedge clk);
    check($sformatf("v%0d resp_pulse_end", n), {31'd0, resp_valid}, 32'd0);
    check($sformatf("v%0d ready_after", n), {31'd0, req_ready}, 32'd1);
    $display("vec %0d: we=%0b f3=%03b addr=0x%08h -> cause=%0d rdata=0x%08h lat=%0d",
             n, v.we, v.f3, v.addr, resp_cause, resp_rdata, lat);
  endtask

  vec_t vecs[$];
  logic [31:0] snap;
  int          wr_snap;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    pre_we = 1'b0; pre_idx = 12'd0; pre_data = 32'd0; mem_clr = 1'b1;
    wr_count = 0; bad_wr = 0; last_wr_addr = 32'd0;
    pass_count = 0; total_count = 0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_cause", {30'd0, resp_cause}, 32'd0);
    check("rst dmem_wen", {31'd0, dmem_wen}, 32'd0);
    check("rst dmem_addr", dmem_addr, 32'd0);
    check("rst dmem_wdata", dmem_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check("release req_ready", {31'd0, req_ready}, 32'd1);

    // ---- directed vectors ----
    vecs.push_back(mk(0, 3'b010, 32'h400, 0, 1, 32'h8899AABB, 0, 32'h8899AABB, 2, 0, 32'h8899AABB));
    vecs.push_back(mk(0, 3'b000, 32'h403, 0, 1, 32'h8899AABB, 0, 32'hFFFFFF88, 2, 0, 32'h8899AABB));
    vecs.push_back(mk(0, 3'b100, 32'h403, 0, 1, 32'h8899AABB, 0, 32'h00000088, 2, 0, 32'h8899AABB));
    vecs.push_back(mk(0, 3'b001, 32'h402, 0, 1, 32'h8899AABB, 0, 32'hFFFF8899, 2, 0, 32'h8899AABB));
    vecs.push_back(mk(0, 3'b101, 32'h400, 0, 1, 32'h8899AABB, 0, 32'h0000AABB, 2, 0, 32'h8899AABB));
    vecs.push_back(mk(0, 3'b000, 32'h401, 0, 1, 32'h8899AA3B, 0, 32'hFFFFFFAA, 2, 0, 32'h8899AA3B));
    vecs.push_back(mk(0, 3'b000, 32'h400, 0, 1, 32'h8899AA3B, 0, 32'h0000003B, 2, 0, 32'h8899AA3B));
    vecs.push_back(mk(1, 3'b000, 32'h402, 32'hFFFFFF5A, 1, 32'h11223344, 0, 0, 3, 1, 32'h115A3344));
    vecs.push_back(mk(1, 3'b001, 32'h602, 32'h1234BEEF, 1, 32'h11223344, 0, 0, 3, 1, 32'hBEEF3344));
    vecs.push_back(mk(1, 3'b001, 32'h600, 32'h0000BEEF, 1, 32'h11223344, 0, 0, 3, 1, 32'h1122BEEF));
    vecs.push_back(mk(1, 3'b000, 32'h3FFF, 32'h00000077, 1, 32'h00000000, 0, 0, 3, 1, 32'h77000000));
    vecs.push_back(mk(1, 3'b010, 32'h500, 32'hCAFEF00D, 1, 32'h00000000, 0, 0, 2, 1, 32'hCAFEF00D));
    vecs.push_back(mk(1, 3'b001, 32'h401, 32'hFFFF, 1, 32'h11223344, 1, 0, 1, 0, 32'h11223344));
    vecs.push_back(mk(0, 3'b010, 32'h402, 0, 1, 32'h55667788, 1, 0, 1, 0, 32'h55667788));
    vecs.push_back(mk(1, 3'b010, 32'h3FC, 32'hDEADBEEF, 1, 32'h12345678, 2, 0, 1, 0, 32'h12345678));
    vecs.push_back(mk(1, 3'b000, 32'h3FF, 32'h000000EE, 1, 32'h12345678, 2, 0, 1, 0, 32'h12345678));
    vecs.push_back(mk(0, 3'b010, 32'd16380, 0, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 2, 0, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 3'b010, 32'd16384, 0, 0, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b011, 32'h400, 0, 1, 32'h0BADF00D, 3, 0, 1, 0, 32'h0BADF00D));
    vecs.push_back(mk(1, 3'b100, 32'h404, 32'h000000AB, 1, 32'h01020304, 3, 0, 1, 0, 32'h01020304));
    vecs.push_back(mk(1, 3'b101, 32'h404, 32'h0000ABCD, 1, 32'h01020304, 3, 0, 1, 0, 32'h01020304));
    vecs.push_back(mk(0, 3'b110, 32'h404, 0, 1, 32'h01020304, 3, 0, 1, 0, 32'h01020304));
    vecs.push_back(mk(0, 3'b111, 32'h401, 0, 1, 32'h01020304, 3, 0, 1, 0, 32'h01020304));
    vecs.push_back(mk(1, 3'b001, 32'h001, 32'h1111, 0, 0, 1, 0, 1, 0, 0));

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // ---- SB must leave neighbouring words untouched ----
    preload(32'h700, 32'hAAAAAAAA);
    preload(32'h708, 32'hBBBBBBBB);
    run_vec(100, mk(1, 3'b000, 32'h705, 32'h000000C3, 1, 32'h44332211, 0, 0, 3, 1, 32'h4433C311));
    check("neighbour_below", mem[12'h700 >> 2], 32'hAAAAAAAA);
    check("neighbour_above", mem[12'h708 >> 2], 32'hBBBBBBBB);

    // ---- reset during WRITE of SW to 0x500 ----
    snap = mem[12'h500 >> 2];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h500; req_wdata = 32'h12345678;
    wr_snap = wr_count;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst dmem_wen", {31'd0, dmem_wen}, 32'd0);
    check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst ready_after", {31'd0, req_ready}, 32'd1);
    check("midrst no_resp", {31'd0, resp_valid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrst no_late_resp", {31'd0, resp_valid}, 32'd0);
    end
    check("midrst mem_unchanged", mem[12'h500 >> 2], snap);
    check("midrst no_write", wr_count - wr_snap, 0);
    $display("midrst: mem[0x500]=0x%08h writes=%0d", mem[12'h500 >> 2], wr_count - wr_snap);

    // ---- global write-safety check ----
    check("unsafe_writes", bad_wr, 0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store initiator that drives the word-wide, little-endian data-memory port of the unified RAM on behalf of the core.
- Converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests into word reads and writes. Sub-word stores use read-modify-write, because the RAM only writes full words.
- Checks alignment, range and the protected instruction region before touching memory. Returns one response per accepted request.

Parameters:
- MEM_BYTES, 16384: size of the addressable RAM in bytes. A word access is legal only if its aligned word address is <= MEM_BYTES-4.
- PROTECT_BASE, 32'h0000_0400: stores to byte addresses below this value are faulted and never issued. Loads below it are allowed.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept a request (high only in IDLE and not in reset)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only)
- req_addr  input  32  byte address
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors
- resp_cause  output  2  0 ok, 1 misaligned, 2 access fault, 3 illegal funct3
- dmem_wen  output  1  RAM write enable
- dmem_addr  output  32  RAM byte address, always word-aligned
- dmem_wdata  output  32  RAM write data
- dmem_rdata  input  32  RAM read data, combinational from dmem_addr

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Accept: req_valid && req_ready at edge T latches addr, funct3, we and wdata. Define waddr = addr & ~3 and lane = addr[1:0].
- Checks at accept, in priority order:
  - Illegal funct3 (011, 110, 111, or 100/101 with we=1) -> cause 3.
  - Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) -> cause 1.
  - waddr > MEM_BYTES-4, or a store with addr < PROTECT_BASE -> cause 2.
  - Any error: go to RESP with no memory access issued.
- Legal request transitions:
  - Load -> LOAD.
  - SW -> WRITE.
  - SB/SH -> RMW_RD.
- LOAD (cycle T+1):
  - dmem_addr = waddr.
  - Extract the byte or halfword at the lane from dmem_rdata, extend it, and register it into resp_rdata.
  - Next state RESP.
- RMW_RD (cycle T+1):
  - dmem_addr = waddr.
  - Register a merge word: dmem_rdata with the target byte/halfword lane replaced by req_wdata[7:0] or [15:0].
  - Next state WRITE.
- WRITE:
  - dmem_addr = waddr, dmem_wen = 1.
  - dmem_wdata = req_wdata for SW, or the merge word for SB/SH.
  - Next state RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_cause and resp_rdata valid.
  - Next state IDLE. There is no response backpressure; the core must take it.
- Latency from the accept edge to resp_valid:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
  - The next request can be accepted the cycle after RESP.
- Outside LOAD/RMW_RD/WRITE: dmem_addr = 0, dmem_wdata = 0, dmem_wen = 0.
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; resp_cause 0; dmem_wen 0; dmem_addr 0; dmem_wdata 0. req_ready is 0 while rst is high and 1 on the first cycle after release.
- Reset mid-operation: dmem_wen is gated by !rst in the same cycle, so no partial write is issued and no response is produced. The operation is dropped.
- Sign extension:
  - LB/LH replicate bit 7 / bit 15.
  - LBU/LHU zero-fill.
  - LW passes the word through.
- The block never issues a write to any address below PROTECT_BASE or to any address that is not word-aligned.

Test Plan:
- LW at 0x400 with mem = 0x8899AABB -> dmem_addr 0x400 at T+1; resp_valid at T+2 with rdata 0x8899AABB, cause 0.
- LB at 0x403 and LBU at 0x403 on the same word -> rdata 0xFFFFFF88 and 0x00000088 respectively.
- SB 0x5A at 0x402 onto word 0x11223344 -> one RMW_RD, then one write of 0x115A3344 to 0x400; resp at T+3; no other words modified.
- SH at 0x401 -> cause 1 at T+1, dmem_wen never asserted. SW at 0x3FC -> cause 2, no write. LW at 16380 is legal; LW at 16384 -> cause 2.
- funct3 011, and SBU (we=1, funct3 100) -> cause 3, no memory access; req_ready returns high 2 cycles after accept.
- Assert rst during WRITE of an SW to 0x500 -> dmem_wen is 0 in that cycle, memory is unchanged, no resp_valid, and req_ready=1 the cycle after rst drops.
